alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_result_fifo.sv | 106 ++++++++++
 tb/tb_alu_result_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Show-ahead FIFO that buffers ALU result words with their
//               carry and compare flags. Optional carry counting is enabled
//               by defining ALU_RESULT_FIFO_CARRY_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  // 'final' is a reserved word in SystemVerilog, hence the suffix
  input  logic [3:0] final_res,
  input  logic       final_carry,
  input  logic       EQ,
  input  logic       A_GT_B,
  input  logic       B_GT_A,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic [3:0] out_flags,
  output logic [4:0] count,
  output logic       flag_err,
  output logic [7:0] carry_cnt
);

  localparam int         c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] c_FULL  = 5'(DEPTH);

  logic [3:0]      r_mem_result [DEPTH];
  logic [3:0]      r_mem_flags  [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [4:0]      r_count;
  logic            r_flag_err;
  logic            w_push;
  logic            w_pop;
  logic            w_flags_bad;

  // Handshake status comes only from the registered occupancy
  assign in_ready    = (r_count != c_FULL);
  assign out_valid   = (r_count != 5'd0);
  assign count       = r_count;
  assign flag_err    = r_flag_err;

  assign w_push      = in_valid && in_ready;
  assign w_pop       = out_valid && out_ready;
  assign w_flags_bad = !$onehot({EQ, A_GT_B, B_GT_A});

  assign out_result  = r_mem_result[r_rd_ptr];
  assign out_flags   = r_mem_flags[r_rd_ptr];

  // Storage carries no reset; stale contents are never presented as valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= final_res;
      r_mem_flags[r_wr_ptr]  <= {final_carry, EQ, A_GT_B, B_GT_A};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_flag_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_flags_bad) begin
        r_flag_err <= 1'b1;
      end
    end
  end

`ifdef ALU_RESULT_FIFO_CARRY_CNT_EN
  logic [7:0] r_carry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry_cnt <= 8'd0;
    end else if (w_push && final_carry && (r_carry_cnt != 8'hFF)) begin
      r_carry_cnt <= r_carry_cnt + 8'd1;
    end
  end

  assign carry_cnt = r_carry_cnt;
`else
  assign carry_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_fifo
// Description : Directed bench for alu_result_fifo with a queue-based
//               reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
`ifdef ALU_RESULT_FIFO_CARRY_CNT_EN
  localparam int EXP_CARRY_SAT = 255;
`else
  localparam int EXP_CARRY_SAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] final_res;
  logic       final_carry;
  logic       EQ;
  logic       A_GT_B;
  logic       B_GT_A;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [4:0] count;
  logic       flag_err;
  logic [7:0] carry_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .final_res  (final_res),
    .final_carry(final_carry),
    .EQ         (EQ),
    .A_GT_B     (A_GT_B),
    .B_GT_A     (B_GT_A),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .count      (count),
    .flag_err   (flag_err),
    .carry_cnt  (carry_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus sticky error and counter
  logic [3:0] m_res[$];
  logic [3:0] m_flg[$];
  bit         m_err;
  int         m_carry;

  always @(posedge clk or posedge rst) begin : model
    bit push, pop;
    if (rst) begin
      m_res.delete();
      m_flg.delete();
      m_err   = 1'b0;
      m_carry = 0;
    end else begin
      push = in_valid && (m_res.size() < DEPTH);
      pop  = out_ready && (m_res.size() > 0);
      if (pop) begin
        void'(m_res.pop_front());
        void'(m_flg.pop_front());
      end
      if (push) begin
        m_res.push_back(final_res);
        m_flg.push_back({final_carry, EQ, A_GT_B, B_GT_A});
        if ((int'(EQ) + int'(A_GT_B) + int'(B_GT_A)) != 1) m_err = 1'b1;
`ifdef ALU_RESULT_FIFO_CARRY_CNT_EN
        if (final_carry && m_carry < 255) m_carry++;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("count",     32'(count),     32'(m_res.size()));
      chk("out_valid", 32'(out_valid), 32'(m_res.size() != 0));
      chk("in_ready",  32'(in_ready),  32'(m_res.size() != DEPTH));
      chk("flag_err",  32'(flag_err),  32'(m_err));
      chk("carry_cnt", 32'(carry_cnt), 32'(m_carry));
      if (m_res.size() > 0) begin
        chk("out_result", 32'(out_result), 32'(m_res[0]));
        chk("out_flags",  32'(out_flags),  32'(m_flg[0]));
      end
    end
  end

  task automatic wr(input logic [3:0] d);
    in_valid  = 1'b1;
    final_res = d;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; final_res = 4'h0;
    final_carry = 1'b0; EQ = 1'b0; A_GT_B = 1'b0; B_GT_A = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_flag_err",  32'(flag_err),  32'd0);
    chk("rst_carry_cnt", 32'(carry_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single pass
    wr(4'hF);
    chk("single_valid",  32'(out_valid),  32'd1);
    chk("single_result", 32'(out_result), 32'hF);
    chk("single_flags",  32'(out_flags),  32'b0001);
    chk("single_count",  32'(count),      32'd1);
    pop1();
    chk("single_drain", 32'(count), 32'd0);

    // Fill, overflow attempt, ordered drain
    for (int i = 1; i <= 4; i++) wr(4'(i));
    chk("fill_count", 32'(count),    32'd4);
    chk("fill_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; final_res = 4'h9; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("full_no_write_through", 32'(count), 32'd3);
    chk("full_head_after_pop",   32'(out_result), 32'd2);
    for (int i = 2; i <= 4; i++) begin
      chk("drain_order", 32'(out_result), 32'(i));
      pop1();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count=2 with pointer wrap
    wr(4'h5);
    wr(4'h6);
    chk("simul_start", 32'(count), 32'd2);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; final_res = 4'(7 + i);
      @(negedge clk);
      chk("simul_count", 32'(count),      32'd2);
      chk("simul_head",  32'(out_result), 32'(6 + i));
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk("simul_drained", 32'(count), 32'd0);

    // Asynchronous reset in the middle of operation
    wr(4'h1); wr(4'h2); wr(4'h3);
    chk("pre_rst_count", 32'(count), 32'd3);
    mid_reset();
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count),     32'd0);
    chk("async_rst_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr(4'hA);
    chk("post_rst_head",  32'(out_result), 32'hA);
    chk("post_rst_count", 32'(count),      32'd1);
    pop1();

    // Sticky flag error
    EQ = 1'b1; A_GT_B = 1'b1; B_GT_A = 1'b0;
    wr(4'h3);
    EQ = 1'b0; A_GT_B = 1'b0; B_GT_A = 1'b1;
    chk("flag_err_set", 32'(flag_err), 32'd1);
    pop1();
    @(negedge clk);
    chk("flag_err_sticky", 32'(flag_err), 32'd1);
    chk("flag_err_empty",  32'(count),    32'd0);
    mid_reset();
    chk("flag_err_cleared", 32'(flag_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Carry counting: 300 accepted writes with carry set
    in_valid = 1'b1; out_ready = 1'b1; final_carry = 1'b1; final_res = 4'hC;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 9) chk("carry_cnt_10", 32'(carry_cnt), 32'(EXP_CARRY_SAT == 0 ? 0 : 10));
    end
    in_valid = 1'b0; final_carry = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("carry_cnt_sat", 32'(carry_cnt), 32'(EXP_CARRY_SAT));
    chk("carry_empty",   32'(count),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
